// File: rtl/mux_rr_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package mux_rr_sched_pkg;

    // Scheduler FSM encoding: one bit is enough for two states.
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // beat_cnt width; MAX_BEATS <= 255 keeps the counter from wrapping.
    localparam int BEAT_W = 8;

    // Ceiling log2, used to check that SW can address all K requesters.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// Rotating-priority picker: first set req bit scanning from ptr upward with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the result.
module rr_pick
    import mux_rr_sched_pkg::*;
#(
    parameter int K  = 64,
    parameter int SW = 6
) (
    input  logic [K-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    // Scan offsets from farthest to nearest so the lowest offset from ptr wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int off = K - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= K) j = j - K;
            if (req[j]) begin
                found = 1'b1;
                idx   = j[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one Kx1 mux: grants one requester, holds sel for a burst.
// Latency: req seen at edge n -> sel/grant registered at edge n; out_valid combinational from req[sel].
// Backpressure: out_ready low freezes sel and beat_cnt indefinitely; release on MAX_BEATS or req withdraw.
module mux_rr_sched
    import mux_rr_sched_pkg::*;
#(
    parameter int K         = 64,
    parameter int SW        = 6,
    parameter int MAX_BEATS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [K-1:0]      req,
    input  logic              out_ready,
    output logic [SW-1:0]     sel,
    output logic [K-1:0]      grant,
    output logic              out_valid,
    output logic [BEAT_W-1:0] beat_cnt
);

    // Elaboration-time parameter sanity checks.
    if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_max_beats
        $error("mux_rr_sched: MAX_BEATS must be in 1..255");
    end
    if (K < 2 || clog2(K) > SW) begin : g_bad_k_sw
        $error("mux_rr_sched: need 2 <= K <= 2**SW");
    end

    localparam int                NSEL      = 1 << SW;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    state_t             state;
    logic [SW-1:0]      ptr;
    logic               pick_found;
    logic [SW-1:0]      pick_idx;
    logic [K-1:0]       pick_onehot;
    logic [NSEL-1:0]    req_pad;
    logic               req_cur;
    logic               xfer;
    logic               last_beat;
    logic               rel;

    rr_pick #(
        .K  (K),
        .SW (SW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Zero-extend req to the full select range so req[sel] never indexes out of range.
    always_comb begin
        req_pad        = '0;
        req_pad[K-1:0] = req;
    end

    assign req_cur   = req_pad[sel];
    assign out_valid = (state == S_ACTIVE) && req_cur;
    assign xfer      = out_valid && out_ready;
    assign last_beat = xfer && (beat_cnt == LAST_BEAT);
    assign rel       = (state == S_ACTIVE) && (!req_cur || last_beat);

    // One-hot form of the picked index, loaded into grant when a burst starts.
    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < K; i++) begin
            pick_onehot[i] = (pick_idx == SW'(i));
        end
    end

    // Scheduler FSM: grant in IDLE, count beats and release in ACTIVE; sel only moves in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            sel      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && pick_found) begin
                        sel      <= pick_idx;
                        grant    <= pick_onehot;
                        beat_cnt <= '0;
                        state    <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (rel) begin
                        ptr      <= (sel == SW'(K - 1)) ? '0 : sel + SW'(1);
                        grant    <= '0;
                        beat_cnt <= '0;
                        state    <= S_IDLE;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched at K=4, SW=2, MAX_BEATS=3.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: exercised directly through out_ready.
module tb_mux_rr_sched;

    localparam int K         = 4;
    localparam int SW        = 2;
    localparam int MAX_BEATS = 3;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [K-1:0]  req;
    logic          out_ready;
    logic [SW-1:0] sel;
    logic [K-1:0]  grant;
    logic          out_valid;
    logic [7:0]    beat_cnt;

    int vectors;
    int miscompares;

    mux_rr_sched #(
        .K         (K),
        .SW        (SW),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [SW-1:0] e_sel, input logic [K-1:0] e_grant,
                             input logic e_valid, input logic [7:0] e_cnt);
        check_vec({tag, ".sel"},   32'(sel),       32'(e_sel));
        check_vec({tag, ".grant"}, 32'(grant),     32'(e_grant));
        check_vec({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
        check_vec({tag, ".cnt"},   32'(beat_cnt),  32'(e_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [SW-1:0] rr_seq [5];
        vectors     = 0;
        miscompares = 0;
        rr_seq      = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n = 1'b0; en = 1'b0; req = '0; out_ready = 1'b0;
        step(); step();
        check_all("reset", 2'd0, 4'b0000, 1'b0, 8'd0);
        rst_n = 1'b1;
        step();
        check_all("post_reset_idle", 2'd0, 4'b0000, 1'b0, 8'd0);

        // Round-robin order with all requesting and no backpressure.
        en = 1'b1; req = 4'b1111; out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            step();
            check_all($sformatf("rr%0d_b0", g), rr_seq[g], 4'b0001 << rr_seq[g], 1'b1, 8'd0);
            step();
            check_vec($sformatf("rr%0d_b1.cnt", g), 32'(beat_cnt), 32'd1);
            step();
            check_all($sformatf("rr%0d_b2", g), rr_seq[g], 4'b0001 << rr_seq[g], 1'b1, 8'd2);
            step();
            check_all($sformatf("rr%0d_idle", g), rr_seq[g], 4'b0000, 1'b0, 8'd0);
        end
        // ptr is now 1.
        req = 4'b0000; out_ready = 1'b0;
        step();
        check_all("no_req_idle", 2'd0, 4'b0000, 1'b0, 8'd0);

        // Backpressure on requester 2.
        req = 4'b0100;
        step();
        check_all("bp_grant", 2'd2, 4'b0100, 1'b1, 8'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            check_all($sformatf("bp_hold%0d", c), 2'd2, 4'b0100, 1'b1, 8'd0);
        end
        out_ready = 1'b1;
        step();
        check_vec("bp_x1.cnt", 32'(beat_cnt), 32'd1);
        step();
        check_vec("bp_x2.cnt", 32'(beat_cnt), 32'd2);
        step();
        check_all("bp_release", 2'd2, 4'b0000, 1'b0, 8'd0);

        // ptr is now 3; lone req[1] must be found by wrapping.
        req = 4'b0010;
        step();
        check_all("wrap_grant", 2'd1, 4'b0010, 1'b1, 8'd0);
        step(); step(); step();
        check_all("wrap_release", 2'd1, 4'b0000, 1'b0, 8'd0);
        step();
        check_all("wrap_regrant", 2'd1, 4'b0010, 1'b1, 8'd0);

        // Withdraw after one beat.
        step();
        check_vec("wd_beat1.cnt", 32'(beat_cnt), 32'd1);
        req = 4'b0000;
        #1;
        check_vec("wd_valid_drop", 32'(out_valid), 32'd0);
        check_vec("wd_grant_held", 32'(grant), 32'b0010);
        step();
        check_all("wd_idle", 2'd1, 4'b0000, 1'b0, 8'd0);
        // ptr should be 2: with req 3 and 1 pending, 3 wins.
        req = 4'b1010;
        step();
        check_all("wd_ptr2", 2'd3, 4'b1000, 1'b1, 8'd0);
        req = 4'b0000;
        step();
        check_all("wd_ptr2_rel", 2'd3, 4'b0000, 1'b0, 8'd0);

        // Enable gating; ptr is now 0.
        en = 1'b0; req = 4'b1000;
        step(); step(); step();
        check_all("en_off_idle", 2'd3, 4'b0000, 1'b0, 8'd0);
        en = 1'b1;
        step();
        check_all("en_on_grant", 2'd3, 4'b1000, 1'b1, 8'd0);
        en = 1'b0;
        step();
        check_all("en_off_b1", 2'd3, 4'b1000, 1'b1, 8'd1);
        step();
        check_vec("en_off_b2.cnt", 32'(beat_cnt), 32'd2);
        step();
        check_all("en_off_rel", 2'd3, 4'b0000, 1'b0, 8'd0);
        step(); step();
        check_all("en_off_no_regrant", 2'd3, 4'b0000, 1'b0, 8'd0);
        en = 1'b1;
        step();
        check_all("lone_regrant", 2'd3, 4'b1000, 1'b1, 8'd0);

        // Reset in the middle of a burst.
        step();
        check_vec("mid_burst.cnt", 32'(beat_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 2'd0, 4'b0000, 1'b0, 8'd0);
        step();
        check_all("reset_hold", 2'd0, 4'b0000, 1'b0, 8'd0);
        rst_n = 1'b1; en = 1'b0; req = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
